// File: rtl/dds_pkg.sv
// dds_pkg: shared DDS types and timing constants derived from the 27 MHz reference.
//   Contents: pll_sup_state_t (PLL supervisor FSM state, 2-bit) and the default
//   cycle counts used by pll_lock_supervisor.
package dds_pkg;
    localparam int CLKIN_HZ               = 27_000_000;
    localparam int PLL_RST_CYCLES_DEF     = CLKIN_HZ / 1_000_000;  // 1 us
    localparam int LOCK_STABLE_CYCLES_DEF = CLKIN_HZ / 10_000;     // 100 us
    localparam int RELOCK_TIMEOUT_DEF     = CLKIN_HZ / 100;        // 10 ms
    localparam int GLITCH_CYCLES_DEF      = 4;
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_sup_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
//   Ports: clk (destination clock), rst_n (async active-low reset, clears both flops),
//          d (asynchronous input), q (synchronised output, 2-cycle latency).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives the rPLL reset, qualifies its lock and issues sys_ready.
//   Ports: clkin (27 MHz reference, only clock), reset_n (async active-low reset),
//          pll_lock (PLL lock, asynchronous), pll_reset (to PLL reset pin, active high),
//          sys_ready (PLL output qualified stable), fault (sticky lock timeout),
//          relock_count (lock losses seen in RUN, saturating), state (FSM state, debug).
//   Build option: PLL_SUP_LOSS_FILTER_EN makes a loss in RUN require GLITCH_CYCLES
//   consecutive low lock cycles; without it a single low cycle is a loss.
module pll_lock_supervisor
    import dds_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = PLL_RST_CYCLES_DEF,
    parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
    parameter int RELOCK_TIMEOUT     = RELOCK_TIMEOUT_DEF,
    parameter int GLITCH_CYCLES      = GLITCH_CYCLES_DEF,
    parameter int CNT_W              = 20
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_ready,
    output logic       fault,
    output logic [7:0] relock_count,
    output logic [1:0] state
);
    pll_sup_state_t   cur, nxt;
    logic [CNT_W-1:0] cnt;
    logic             lock_s, loss, timeout;

    sync_2ff u_lock_sync (.clk(clkin), .rst_n(reset_n), .d(pll_lock), .q(lock_s));

    // The shared timer has to reach RELOCK_TIMEOUT-1.
    if (((RELOCK_TIMEOUT - 1) >> CNT_W) != 0 || GLITCH_CYCLES < 1) begin : g_bad_cfg
        $error("pll_lock_supervisor: CNT_W too narrow or GLITCH_CYCLES < 1");
    end

    assign timeout = cnt == CNT_W'(RELOCK_TIMEOUT - 1);

`ifdef PLL_SUP_LOSS_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    logic [GW-1:0] low_cnt;
    // low_cnt holds the number of low cycles already seen, so the current low
    // cycle is the GLITCH_CYCLES-th one when it equals GLITCH_CYCLES-1.
    assign loss = cur == RUN && !lock_s && low_cnt == GW'(GLITCH_CYCLES - 1);
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) low_cnt <= '0;
        else          low_cnt <= (cur != RUN || lock_s || loss) ? '0 : low_cnt + GW'(1);
    end
`else
    assign loss = cur == RUN && !lock_s;
`endif

    // Lock drop beats stable completion; lock arrival beats timeout.
    always_comb begin
        nxt = cur;
        case (cur)
            PLL_RST:   nxt = (cnt == CNT_W'(PLL_RST_CYCLES - 1)) ? WAIT_LOCK : PLL_RST;
            WAIT_LOCK: nxt = lock_s ? STABLE : (timeout ? PLL_RST : WAIT_LOCK);
            STABLE:    nxt = !lock_s ? WAIT_LOCK :
                             (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) ? RUN : STABLE;
            RUN:       nxt = loss ? PLL_RST : RUN;
            default:   nxt = PLL_RST;
        endcase
    end

    // Outputs decode the next state so they move on the same edge as state.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            cur          <= PLL_RST;
            cnt          <= '0;
            pll_reset    <= 1'b1;
            sys_ready    <= 1'b0;
            fault        <= 1'b0;
            relock_count <= '0;
        end else begin
            cur       <= nxt;
            cnt       <= (nxt != cur) ? '0 : cnt + CNT_W'(1);
            pll_reset <= nxt == PLL_RST;
            sys_ready <= nxt == RUN;
            if (cur == WAIT_LOCK && !lock_s && timeout) fault <= 1'b1;
            if (loss && relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
        end
    end

    assign state = cur;
endmodule
